// File: rtl/a2g_ctrl_pkg.sv
// Shared types and field positions for the a2g control/reset sequencer.
// The CTRL_SYNC_EN build option itself is handled in a2g_ctrl_edge_det.
package a2g_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RST_ASSERT = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_READY      = 3'd2,
        ST_FAULT      = 3'd3
    } state_e;

    localparam int CTRL_W      = 3;
    localparam int RST_REQ_BIT = 0;
    localparam int RUN_EN_BIT  = 1;
    localparam int CLR_CNT_BIT = 2;

    localparam int STAT_STATE_LSB   = 0;
    localparam int STAT_LOCKED_BIT  = 3;
    localparam int STAT_TIMEOUT_BIT = 4;
    localparam int STAT_COUNT_LSB   = 16;

    function automatic logic [31:0] pack_status(input state_e     st,
                                                input logic       locked,
                                                input logic       timeout,
                                                input logic [15:0] count);
        logic [31:0] v;
        v = '0;
        v[STAT_STATE_LSB +: 3]   = st;
        v[STAT_LOCKED_BIT]       = locked;
        v[STAT_TIMEOUT_BIT]      = timeout;
        v[STAT_COUNT_LSB +: 16]  = count;
        return v;
    endfunction

endpackage

// File: rtl/a2g_ctrl_edge_det.sv
// Rising-edge detector for the control bits; history resets to ones so levels held through reset are not edges.
// Build option: CTRL_SYNC_EN inserts a 2-stage input register (reset to ones) ahead of the detector.
module a2g_ctrl_edge_det #(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_level,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] w_ctrl_s;
    logic [W-1:0] r_prev;

`ifdef CTRL_SYNC_EN
    logic [W-1:0] r_sync1;
    logic [W-1:0] r_sync2;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= i_d;
            r_sync2 <= r_sync1;
        end
    end

    assign w_ctrl_s = r_sync2;
`else
    assign w_ctrl_s = i_d;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prev <= '1;
        end else begin
            r_prev <= w_ctrl_s;
        end
    end

    assign o_level = w_ctrl_s;
    assign o_rise  = w_ctrl_s & ~r_prev;

endmodule

// File: rtl/a2g_ctrl_rst_sequencer.sv
// Turns the a2g_ctrl_rst register word into a timed a2g reset, a gated run enable and clear strobes.
// Build option: CTRL_SYNC_EN (see a2g_ctrl_edge_det) delays every ctrl-driven response by 2 cycles.
module a2g_ctrl_rst_sequencer
    import a2g_ctrl_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int CNT_W        = 16
) (
    input  logic        user_clk,
    input  logic        user_rst_n,
    input  logic [31:0] ctrl_word,
    input  logic        a2g_locked,
    output logic        a2g_rst,
    output logic        a2g_run,
    output logic        cnt_clr,
    output logic [31:0] status_word
);

    localparam int TIMER_MAX = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int TIMER_W   = $clog2(TIMER_MAX);

    logic [CTRL_W-1:0]  w_ctrl_level;
    logic [CTRL_W-1:0]  w_ctrl_rise;
    logic               w_unused_ctrl;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_nxt;
    logic [CNT_W-1:0]   r_rst_count;
    logic [CNT_W-1:0]   w_rst_count_nxt;
    logic               r_timeout;
    logic               w_timeout_nxt;
    logic               r_lock_sync1;
    logic               r_locked_s;
    logic               r_a2g_rst;
    logic               r_a2g_run;
    logic               r_cnt_clr;
    logic [31:0]        r_status;

    a2g_ctrl_edge_det #(
        .W (CTRL_W)
    ) u_edge_det (
        .i_clk   (user_clk),
        .i_rst_n (user_rst_n),
        .i_d     (ctrl_word[CTRL_W-1:0]),
        .o_level (w_ctrl_level),
        .o_rise  (w_ctrl_rise)
    );

    assign w_unused_ctrl = ^{ctrl_word[31:CTRL_W], w_ctrl_level[RST_REQ_BIT],
                             w_ctrl_level[CLR_CNT_BIT], w_ctrl_rise[RUN_EN_BIT]};

    // Lock handshake: a2g_locked is a level from the datapath; once synchronized it is
    // honoured only in WAIT_LOCK (rise) and READY (fall), and needs no acknowledge.
    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            r_lock_sync1 <= 1'b0;
            r_locked_s   <= 1'b0;
        end else begin
            r_lock_sync1 <= a2g_locked;
            r_locked_s   <= r_lock_sync1;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_rst_count_nxt = r_rst_count;
        w_timeout_nxt   = r_timeout;
        if (w_ctrl_rise[RST_REQ_BIT]) begin
            // A new request restarts the sequence from any state, even mid-reset.
            w_state_nxt   = ST_RST_ASSERT;
            w_timer_nxt   = '0;
            w_timeout_nxt = 1'b0;
            if (r_rst_count != '1) begin
                w_rst_count_nxt = r_rst_count + CNT_W'(1);
            end
        end else begin
            case (r_state)
                ST_RST_ASSERT: begin
                    if (r_timer == TIMER_W'(RST_CYCLES - 1)) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + TIMER_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (r_locked_s) begin
                        w_state_nxt = ST_READY;
                        w_timer_nxt = '0;
                    end else if (r_timer == TIMER_W'(LOCK_TIMEOUT - 1)) begin
                        w_state_nxt   = ST_FAULT;
                        w_timer_nxt   = '0;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer + TIMER_W'(1);
                    end
                end
                ST_READY: begin
                    if (!r_locked_s) begin
                        w_state_nxt = ST_FAULT;
                    end
                end
                ST_FAULT: begin
                    w_state_nxt = ST_FAULT;
                end
                default: begin
                    w_state_nxt = ST_RST_ASSERT;
                    w_timer_nxt = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            r_state     <= ST_RST_ASSERT;
            r_timer     <= '0;
            r_rst_count <= '0;
            r_timeout   <= 1'b0;
            r_a2g_rst   <= 1'b1;
            r_a2g_run   <= 1'b0;
            r_cnt_clr   <= 1'b0;
            r_status    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_rst_count <= w_rst_count_nxt;
            r_timeout   <= w_timeout_nxt;
            r_a2g_rst   <= (w_state_nxt == ST_RST_ASSERT);
            r_a2g_run   <= (w_state_nxt == ST_READY) && w_ctrl_level[RUN_EN_BIT];
            r_cnt_clr   <= w_ctrl_rise[CLR_CNT_BIT];
            r_status    <= pack_status(r_state, r_locked_s, r_timeout, 16'(r_rst_count));
        end
    end

    assign a2g_rst     = r_a2g_rst;
    assign a2g_run     = r_a2g_run;
    assign cnt_clr     = r_cnt_clr;
    assign status_word = r_status;

endmodule

// File: tb/tb_a2g_ctrl_rst_sequencer.sv
// Bench for a2g_ctrl_rst_sequencer: cycle-level reference model plus directed literal checks and random traffic.
module tb_a2g_ctrl_rst_sequencer;

`ifdef CTRL_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int RST_CYCLES   = 16;
    localparam int LOCK_TIMEOUT = 1024;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    localparam int M_RST   = 0;
    localparam int M_WAIT  = 1;
    localparam int M_READY = 2;
    localparam int M_FAULT = 3;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        user_rst_n;
    logic [31:0] ctrl_word;
    logic        a2g_locked;
    logic        a2g_rst;
    logic        a2g_run;
    logic        cnt_clr;
    logic [31:0] status_word;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    a2g_ctrl_rst_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .CNT_W        (CNT_W)
    ) dut (
        .user_clk    (clk),
        .user_rst_n  (user_rst_n),
        .ctrl_word   (ctrl_word),
        .a2g_locked  (a2g_locked),
        .a2g_rst     (a2g_rst),
        .a2g_run     (a2g_run),
        .cnt_clr     (cnt_clr),
        .status_word (status_word)
    );

    // ---------------- reference model ----------------
    // Expected {a2g_rst, a2g_run, cnt_clr, status_word} after each rising edge.
    logic [34:0] exp_q[$];
    logic [2:0]  m_cq[$];
    logic        m_lq[$];
    logic [2:0]  m_prev;
    int          m_cyc;
    int          m_enter;
    int          m_state;
    int          m_cnt;
    logic        m_to;

    initial m_cyc = 0;

    always @(posedge clk) begin
        logic [2:0]  cs;
        logic [2:0]  rise;
        logic        ls;
        logic [31:0] st;
        m_cyc = m_cyc + 1;
        if (!user_rst_n) begin
            m_cq.delete();
            repeat (SYNC_LAT) m_cq.push_back(3'b111);
            m_lq.delete();
            m_lq.push_back(1'b0);
            m_lq.push_back(1'b0);
            m_prev  = 3'b111;
            m_state = M_RST;
            m_enter = m_cyc;
            m_cnt   = 0;
            m_to    = 1'b0;
            exp_q.push_back({1'b1, 1'b0, 1'b0, 32'd0});
        end else begin
            m_cq.push_back(ctrl_word[2:0]);
            cs = m_cq.pop_front();
            ls = m_lq.pop_front();
            m_lq.push_back(a2g_locked);
            rise   = cs & ~m_prev;
            m_prev = cs;
            st = {16'(m_cnt), 11'd0, m_to, ls, 3'(m_state)};
            if (rise[0]) begin
                m_state = M_RST;
                m_enter = m_cyc;
                m_to    = 1'b0;
                if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            end else if (m_state == M_RST && (m_cyc - m_enter) == RST_CYCLES) begin
                m_state = M_WAIT;
                m_enter = m_cyc;
            end else if (m_state == M_WAIT && ls) begin
                m_state = M_READY;
                m_enter = m_cyc;
            end else if (m_state == M_WAIT && (m_cyc - m_enter) == LOCK_TIMEOUT) begin
                m_state = M_FAULT;
                m_enter = m_cyc;
                m_to    = 1'b1;
            end else if (m_state == M_READY && !ls) begin
                m_state = M_FAULT;
                m_enter = m_cyc;
            end
            exp_q.push_back({m_state == M_RST, (m_state == M_READY) && cs[1], rise[2], st});
        end
    end

    // ---------------- scoreboard ----------------
    int n_vec;
    int n_err;

    task automatic cycle_compare();
        logic [34:0] e;
        logic [34:0] a;
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        a = {a2g_rst, a2g_run, cnt_clr, status_word};
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL model_cmp t=%0t got rst=%b run=%b clr=%b status=%h exp rst=%b run=%b clr=%b status=%h",
                     $time, a[34], a[33], a[32], a[31:0], e[34], e[33], e[32], e[31:0]);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            cycle_compare();
        end
    endtask

    task automatic count_rst_high(output int n);
        n = 0;
        while (a2g_rst && n < 60) begin
            n++;
            tick(1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int first;
        n_vec = 0;
        n_err = 0;
        user_rst_n = 1'b0;
        ctrl_word  = 32'h0;
        a2g_locked = 1'b0;
        tick(3);
        check("reset_outputs", {28'd0, a2g_rst, a2g_run, cnt_clr, 1'b0}, 32'h8);
        check("reset_status", status_word, 32'h0);

        // power-up sequence, lock arrives at WAIT_LOCK entry
        user_rst_n = 1'b1;
        count_rst_high(n);
        check("t1_rst_len", n, 32'd16);
        a2g_locked = 1'b1;
        tick(3);
        check("t1_status_wait", status_word, 32'h0000_0009);
        tick(1);
        check("t1_status_ready", status_word, 32'h0000_000A);

        // run enable follows run_en with one cycle latency
        ctrl_word = 32'h2;
        tick(SYNC_LAT);
        check("t2_run_before", {31'd0, a2g_run}, 32'd0);
        tick(1);
        check("t2_run_on", {31'd0, a2g_run}, 32'd1);
        ctrl_word = 32'h0;
        tick(SYNC_LAT);
        check("t2_run_hold", {31'd0, a2g_run}, 32'd1);
        tick(1);
        check("t2_run_off", {31'd0, a2g_run}, 32'd0);

        // clear strobe
        ctrl_word = 32'h4;
        n = 0;
        first = -1;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            if (cnt_clr) begin
                n++;
                first = i;
            end
            if (i == 2) ctrl_word = 32'h0;
        end
        check("t5_clr_count", n, 32'd1);
        check("t5_clr_latency", first, 1 + SYNC_LAT);

        // lock never arrives: timeout after LOCK_TIMEOUT cycles
        user_rst_n = 1'b0;
        a2g_locked = 1'b0;
        ctrl_word  = 32'h2;
        tick(2);
        user_rst_n = 1'b1;
        count_rst_high(n);
        n = 0;
        while (status_word[2:0] != 3'd3 && n < 1100) begin
            tick(1);
            n++;
        end
        check("t3_fault_delay", n, 32'd1025);
        check("t3_timeout_flag", {31'd0, status_word[4]}, 32'd1);
        check("t3_run_low", {31'd0, a2g_run}, 32'd0);

        // software reset request held 100 cycles
        a2g_locked = 1'b1;
        ctrl_word  = 32'h1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (a2g_rst) n++;
        end
        ctrl_word = 32'h0;
        check("t4_pulse_len", n, 32'd16);
        tick(4);
        check("t4_status", status_word, 32'h0001_000A);

        // second request at timer 8 restarts the sequence
        ctrl_word = 32'h1;
        tick(1);
        ctrl_word = 32'h0;
        tick(8);
        ctrl_word = 32'h1;
        tick(1);
        ctrl_word = 32'h0;
        tick(SYNC_LAT);
        count_rst_high(n);
        check("t6_restart_len", n, 32'd16);
        tick(20);

        // request coincident with lock loss in READY
        a2g_locked = 1'b0;
        tick(2 - SYNC_LAT);
        ctrl_word = 32'h1;
        tick(1);
        check("t6_req_beats_lockloss", {31'd0, a2g_rst}, 32'd1);
        tick(1);
        check("t6_state_rst", {29'd0, status_word[2:0]}, 32'd0);
        ctrl_word  = 32'h0;
        a2g_locked = 1'b1;

        // saturation of the request counter
        for (int i = 0; i < 20; i++) begin
            ctrl_word = 32'h1;
            tick(1);
            ctrl_word = 32'h0;
            tick(1);
        end
        tick(4 + SYNC_LAT);
        check("t4_count_sat", {16'd0, status_word[31:16]}, CNT_MAX);

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] w;
            w = ctrl_word;
            if ($urandom_range(0, 7) == 0) w[1] = ~w[1];
            if ($urandom_range(0, 5) == 0) w[2] = ~w[2];
            if ($urandom_range(0, 99) == 0) w[0] = 1'b1;
            else if (w[0] && $urandom_range(0, 2) == 0) w[0] = 1'b0;
            w[31:3] = 29'($urandom);
            ctrl_word = w;
            if ($urandom_range(0, 49) == 0) a2g_locked = ~a2g_locked;
            user_rst_n = ($urandom_range(0, 999) != 0);
            tick(1);
        end
        user_rst_n = 1'b1;
        tick(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
